sar_search: RTL and testbench
=============================

// Module: sar_search
// PURPOSE
//  Successive-approximation (binary search) controller: the driving end of a
//  magnitude comparator. Presents a probe value, reads back gt/eq/lt and
//  converges on the hidden operand held on the comparator's other input.
//  Sits in front of comp_4bit (WIDTH=4): guess -> comp a, target -> comp b.
// PARAMETERS
//  WIDTH  4  operand width; search range 0 .. 2^WIDTH-1
//  SW     $clog2(WIDTH+2)  width of step counter (derived, not overridden)
// PORTS
//  clk     in   1      rising-edge clock
//  reset   in   1      asynchronous, active-high reset
//  start   in   1      begin a search; sampled only in IDLE
//  cmp_gt  in   1      comparator: guess > target
//  cmp_eq  in   1      comparator: guess == target
//  cmp_lt  in   1      comparator: guess < target
//  guess   out  WIDTH  registered probe value driven to comparator
//  busy    out  1      high in PROBE
//  done    out  1      one-cycle pulse when a search ends
//  found   out  1      last search hit eq; held until next start
//  result  out  WIDTH  matched value (0 if not found); held until next start
//  steps   out  SW     probes used by last search; held until next start
//  err     out  1      only with SAR_SEARCH_ERR_EN (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; guess,result,steps,lo,hi=0;
//    busy,done,found,err=0.
//  - States IDLE -> PROBE -> FIN -> IDLE.
//  - IDLE & start: lo=0, hi=2^WIDTH-1, guess=mid(0,hi), steps=0,
//    found=0, result=0, err=0; next PROBE. start ignored outside IDLE.
//  - mid(lo,hi) = (lo+hi)>>1, sum computed in WIDTH+1 bits (no overflow).
//  - PROBE: comparator is combinational on registered guess; sample each
//    cycle, steps+=1. Priority eq > gt > lt; none high treated as lt.
//    eq: result=guess, found=1, next FIN.
//    gt: if guess==lo -> not found, FIN; else hi=guess-1, guess=mid(lo,hi').
//    lt: if guess==hi -> not found, FIN; else lo=guess+1, guess=mid(lo',hi).
//  - Boundaries: guess==0 & gt and guess==2^WIDTH-1 & lt end the search
//    with found=0 (no underflow/overflow of lo/hi). Consistent comparator
//    always finds target within WIDTH+1 probes; steps never exceeds WIDTH+1.
//  - FIN: done=1 for exactly one cycle, busy=0; next IDLE. guess holds last
//    probe until next start.
//  - Latency: start sampled at edge N; first probe on guess after N; done
//    high in cycle after the deciding probe is sampled.
//  - Reset asserted mid-search aborts immediately; no done pulse.
// CONFIGURATION
//  SAR_SEARCH_ERR_EN defined: in PROBE, if cmp_gt/eq/lt is not one-hot,
//    err=1, found=0, result=0, next FIN (done pulses); err held until next
//    start or reset. Illegal code still counts as a step.
//  Not defined: no err port; priority eq>gt>lt applied, none-high = lt.
// TESTING (WIDTH=4, bench models comparator with hidden target T)
//  T=7, start -> one probe (7), done, found=1, result=7, steps=1.
//  T=15 -> probes 7,11,13,14,15; found=1, result=15, steps=5.
//  T=0 -> probes 7,3,1,0; found=1, result=0, steps=4.
//  Comparator stuck cmp_lt=1 -> probes 7,11,13,14,15, then found=0,
//    result=0, steps=5, single done pulse.
//  reset mid-search after 2 probes -> all outputs 0 same cycle, IDLE; start
//    during busy ignored (steps/guess sequence unchanged).
//  ERR_EN: cmp_gt=cmp_lt=1 on first probe -> err=1, found=0, steps=1, done.

Source files
------------

// File: rtl/sar_search_if.sv
// Bundle between the successive-approximation controller and its comparator/host.
// The err signal exists only when SAR_SEARCH_ERR_EN is defined.
interface sar_search_if #(
  parameter int unsigned WIDTH = 4
);
  localparam int unsigned SW = $clog2(WIDTH + 2);

  logic             start;
  logic             cmp_gt;
  logic             cmp_eq;
  logic             cmp_lt;
  logic [WIDTH-1:0] guess;
  logic             busy;
  logic             done;
  logic             found;
  logic [WIDTH-1:0] result;
  logic [SW-1:0]    steps;
`ifdef SAR_SEARCH_ERR_EN
  logic             err;
`endif

  modport master (
    input  start, cmp_gt, cmp_eq, cmp_lt,
`ifdef SAR_SEARCH_ERR_EN
    output err,
`endif
    output guess, busy, done, found, result, steps
  );

  modport slave (
    output start, cmp_gt, cmp_eq, cmp_lt,
`ifdef SAR_SEARCH_ERR_EN
    input  err,
`endif
    input  guess, busy, done, found, result, steps
  );
endinterface

// File: rtl/sar_search.sv
// Binary-search controller driving a magnitude comparator toward a hidden operand.
// Define SAR_SEARCH_ERR_EN to flag non-one-hot comparator codes on the err output.
module sar_search #(
  parameter int unsigned WIDTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  sar_search_if.master bus
);
  localparam int unsigned SW = $clog2(WIDTH + 2);

  typedef enum logic [1:0] {StIdle, StProbe, StFin} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] guess_q, guess_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [SW-1:0]    steps_q, steps_d;
  logic             found_q, found_d;
  logic             illegal;
`ifdef SAR_SEARCH_ERR_EN
  logic             err_q, err_d;
`endif

  // Midpoint with a WIDTH+1 bit sum so lo+hi never wraps.
  function automatic logic [WIDTH-1:0] mid(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[WIDTH:1];
  endfunction

  always_comb begin
`ifdef SAR_SEARCH_ERR_EN
    illegal = !({bus.cmp_gt, bus.cmp_eq, bus.cmp_lt} inside {3'b100, 3'b010, 3'b001});
`else
    illegal = 1'b0;
`endif
  end

  always_comb begin
    state_d  = state_q;
    guess_d  = guess_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    result_d = result_q;
    steps_d  = steps_q;
    found_d  = found_q;
`ifdef SAR_SEARCH_ERR_EN
    err_d    = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          lo_d     = '0;
          hi_d     = '1;
          guess_d  = mid('0, '1);
          steps_d  = '0;
          found_d  = 1'b0;
          result_d = '0;
`ifdef SAR_SEARCH_ERR_EN
          err_d    = 1'b0;
`endif
          state_d  = StProbe;
        end
      end
      StProbe: begin
        steps_d = steps_q + SW'(1);
        if (illegal) begin
`ifdef SAR_SEARCH_ERR_EN
          err_d = 1'b1;
`endif
          state_d = StFin;
        end else if (bus.cmp_eq) begin
          result_d = guess_q;
          found_d  = 1'b1;
          state_d  = StFin;
        end else if (bus.cmp_gt) begin
          if (guess_q == lo_q) begin
            state_d = StFin;
          end else begin
            hi_d    = guess_q - WIDTH'(1);
            guess_d = mid(lo_q, guess_q - WIDTH'(1));
          end
        end else begin
          // No flag asserted falls through here and is treated as lt.
          if (guess_q == hi_q) begin
            state_d = StFin;
          end else begin
            lo_d    = guess_q + WIDTH'(1);
            guess_d = mid(guess_q + WIDTH'(1), hi_q);
          end
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      guess_q  <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      result_q <= '0;
      steps_q  <= '0;
      found_q  <= 1'b0;
`ifdef SAR_SEARCH_ERR_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      guess_q  <= guess_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      result_q <= result_d;
      steps_q  <= steps_d;
      found_q  <= found_d;
`ifdef SAR_SEARCH_ERR_EN
      err_q    <= err_d;
`endif
    end
  end

  always_comb begin
    bus.guess  = guess_q;
    bus.busy   = (state_q == StProbe);
    bus.done   = (state_q == StFin);
    bus.found  = found_q;
    bus.result = result_q;
    bus.steps  = steps_q;
`ifdef SAR_SEARCH_ERR_EN
    bus.err    = err_q;
`endif
  end
endmodule

// File: tb/tb_sar_search.sv
// Directed bench for sar_search: comparator model with hidden target, per-cycle scoreboard.
// Covers SAR_SEARCH_ERR_EN when that macro is defined for the build.
module tb_sar_search;
  localparam int unsigned WIDTH = 4;
  localparam int MaxV = (1 << WIDTH) - 1;

  typedef struct {
    int guess;
    bit busy;
    bit done;
    bit found;
    int result;
    int steps;
    bit err;
  } rec_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  int   mode;    // 0: honest comparator vs target, 1: stuck lt, 2: gt and lt together
  int   target;
  rec_t exp_q[$];
  int   exp_probes[$];
  bit   exp_found;
  int   exp_result;
  bit   exp_err;

  sar_search_if #(.WIDTH(WIDTH)) bus ();

  sar_search #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    bus.cmp_gt = 1'b0;
    bus.cmp_eq = 1'b0;
    bus.cmp_lt = 1'b0;
    if (mode == 1) begin
      bus.cmp_lt = 1'b1;
    end else if (mode == 2) begin
      bus.cmp_gt = 1'b1;
      bus.cmp_lt = 1'b1;
    end else begin
      bus.cmp_gt = (int'(bus.guess) > target);
      bus.cmp_eq = (int'(bus.guess) == target);
      bus.cmp_lt = (int'(bus.guess) < target);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Plain integer binary search over 0..MaxV under the chosen comparator behaviour.
  task automatic build_model();
    int lo = 0;
    int hi = MaxV;
    int g;
    exp_probes.delete();
    exp_found  = 1'b0;
    exp_result = 0;
    exp_err    = 1'b0;
    forever begin
      g = (lo + hi) / 2;
      exp_probes.push_back(g);
      if (mode == 2) begin
        exp_err = 1'b1;
        break;
      end
      if (mode == 0 && g == target) begin
        exp_found  = 1'b1;
        exp_result = g;
        break;
      end
      if (mode == 0 && g > target) begin
        if (g == lo) break;
        hi = g - 1;
      end else begin
        if (g == hi) break;
        lo = g + 1;
      end
    end
  endtask

  task automatic pin_probes(input string name, input int n, input int a0, input int a1,
                            input int a2, input int a3, input int a4);
    int lit[5];
    lit = '{a0, a1, a2, a3, a4};
    chk({name, "_len"}, exp_probes.size(), n);
    for (int i = 0; i < n && i < exp_probes.size(); i++) chk({name, "_probe"}, exp_probes[i], lit[i]);
  endtask

  task automatic push_expect();
    rec_t r;
    int n = exp_probes.size();
    for (int i = 0; i < n; i++) begin
      r = '{guess: exp_probes[i], busy: 1'b1, done: 1'b0, found: 1'b0, result: 0, steps: i,
            err: 1'b0};
      exp_q.push_back(r);
    end
    r = '{guess: exp_probes[n-1], busy: 1'b0, done: 1'b1, found: exp_found, result: exp_result,
          steps: n, err: exp_err};
    exp_q.push_back(r);
    r.done = 1'b0;
    exp_q.push_back(r);
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) @(posedge clk);
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic run_search(input int m, input int t, input bit poke_busy);
    mode   = m;
    target = t;
    build_model();
    pulse_start();
    push_expect();
    if (poke_busy) pulse_start();
    wait_drain();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_guess"}, int'(bus.guess), 0);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_done"}, int'(bus.done), 0);
    chk({tag, "_found"}, int'(bus.found), 0);
    chk({tag, "_result"}, int'(bus.result), 0);
    chk({tag, "_steps"}, int'(bus.steps), 0);
`ifdef SAR_SEARCH_ERR_EN
    chk({tag, "_err"}, int'(bus.err), 0);
`endif
  endtask

  always @(negedge clk) begin
    rec_t r;
    if (!reset && exp_q.size() > 0) begin
      r = exp_q.pop_front();
      chk("guess", int'(bus.guess), r.guess);
      chk("busy", int'(bus.busy), int'(r.busy));
      chk("done", int'(bus.done), int'(r.done));
      chk("found", int'(bus.found), int'(r.found));
      chk("result", int'(bus.result), r.result);
      chk("steps", int'(bus.steps), r.steps);
`ifdef SAR_SEARCH_ERR_EN
      chk("err", int'(bus.err), int'(r.err));
`endif
    end
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    mode      = 0;
    target    = 0;
    bus.start = 1'b0;
    reset     = 1'b1;
    #1 chk_zero("reset");
    #20 reset = 1'b0;

    // Pin the model against hand-derived probe sequences.
    mode = 0; target = 7;  build_model(); pin_probes("m_t7", 1, 7, 0, 0, 0, 0);
    chk("m_t7_found", int'(exp_found), 1);
    mode = 0; target = 15; build_model(); pin_probes("m_t15", 5, 7, 11, 13, 14, 15);
    mode = 0; target = 0;  build_model(); pin_probes("m_t0", 4, 7, 3, 1, 0, 0);
    chk("m_t0_result", exp_result, 0);
    mode = 1; build_model(); pin_probes("m_stuck", 5, 7, 11, 13, 14, 15);
    chk("m_stuck_found", int'(exp_found), 0);

    run_search(0, 7, 1'b0);
    run_search(0, 15, 1'b0);
    run_search(0, 0, 1'b0);
    run_search(1, 0, 1'b0);
    run_search(0, 5, 1'b0);
    run_search(0, 10, 1'b1);  // start pulsed mid-search must be ignored

    // Abort after two probes: outputs clear asynchronously, no done pulse.
    mode = 0; target = 15;
    build_model();
    pulse_start();
    push_expect();
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    exp_q.delete();
    #1 chk_zero("abort");
    @(posedge clk);
    #1 chk_zero("abort_held");
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_done", int'(bus.done), 0);
      chk("abort_idle", int'(bus.busy), 0);
    end

    run_search(0, 12, 1'b0);
`ifdef SAR_SEARCH_ERR_EN
    run_search(2, 0, 1'b0);
    run_search(0, 3, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
